// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] CA_OFF = 7'h7F;

  // Extract the 7-bit active-low pattern of digit d from a packed 8-digit bus.
  function automatic logic [6:0] digit_pat(input logic [55:0] s, input logic [2:0] d);
    digit_pat = s[int'(d) * 7 +: 7];
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Prescaler plus 3-bit digit scan index; produces scan tick and frame end.
module sseg_scan_timer #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] idx_o,
  output logic       tick_o,
  output logic       frame_end_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic [2:0]   idx_q;
  logic [2:0]   idx_d;
  logic         tick_s;

  // Next-state for the prescaler and scan index.
  always_comb begin
    tick_s = (cnt_q == {N{1'b1}});
    cnt_d  = cnt_q + N'(1);
    if (tick_s) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Prescaler and scan index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o       = idx_q;
  assign tick_o      = tick_s;
  assign frame_end_o = tick_s && (idx_q == 3'd7);

endmodule

// File: rtl/sseg_arbiter.sv
// Two-source seven-segment display arbiter: frame-aligned grant switching
// with round-robin tie-break and a per-owner frame quantum under contention.
module sseg_arbiter
  import sseg_pkg::*;
#(
  parameter int N       = 18,
  parameter int QUANTUM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [55:0] seg0,
  input  logic [55:0] seg1,
  output logic [6:0]  CA,
  output logic [7:0]  AN
);

  localparam logic [7:0] QMAX = 8'(QUANTUM - 1);

  logic [2:0] idx_s;
  logic       tick_s;
  logic       frame_end_s;

  arb_state_t state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [7:0] an_q, an_d;
  logic [6:0] ca_q, ca_d;

  sseg_scan_timer #(.N(N)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx_o       (idx_s),
    .tick_o      (tick_s),
    .frame_end_o (frame_end_s)
  );

  // Ownership decision, taken only at frame boundaries so a frame never tears.
  always_comb begin
    state_d = state_q;
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          case (req)
            2'b01:   state_d = OWN0;
            2'b10:   state_d = OWN1;
            2'b11:   state_d = rr_q ? OWN1 : OWN0;
            default: state_d = IDLE;
          endcase
        end
        OWN0: begin
          if (!req[0]) begin
            state_d = req[1] ? OWN1 : IDLE;
          end else if (req[1] && (fcnt_q == QMAX)) begin
            state_d = OWN1;
          end else begin
            state_d = OWN0;
          end
        end
        OWN1: begin
          if (!req[1]) begin
            state_d = req[0] ? OWN0 : IDLE;
          end else if (req[0] && (fcnt_q == QMAX)) begin
            state_d = OWN0;
          end else begin
            state_d = OWN1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Round-robin pointer and frame counter follow the ownership decision.
  always_comb begin
    rr_d   = rr_q;
    fcnt_d = fcnt_q;
    if (state_d != state_q) begin
      fcnt_d = 8'd0;
      if (state_d == OWN0) begin
        rr_d = 1'b1;
      end else if (state_d == OWN1) begin
        rr_d = 1'b0;
      end else begin
        rr_d = rr_q;
      end
    end else if (frame_end_s && (state_q != IDLE) && (fcnt_q < QMAX)) begin
      fcnt_d = fcnt_q + 8'd1;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  // Grant decode from next state, and pin drive from the current owner and digit.
  always_comb begin
    gnt_d = 2'b00;
    an_d  = AN_OFF;
    ca_d  = CA_OFF;
    case (state_d)
      OWN0:    gnt_d = 2'b01;
      OWN1:    gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
    case (state_q)
      OWN0: begin
        an_d = ~(8'b1 << idx_s);
        ca_d = digit_pat(seg0, idx_s);
      end
      OWN1: begin
        an_d = ~(8'b1 << idx_s);
        ca_d = digit_pat(seg1, idx_s);
      end
      default: begin
        an_d = AN_OFF;
        ca_d = CA_OFF;
      end
    endcase
  end

  // Arbiter state and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      fcnt_q  <= 8'd0;
      gnt_q   <= 2'b00;
      an_q    <= AN_OFF;
      ca_q    <= CA_OFF;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      fcnt_q  <= fcnt_d;
      gnt_q   <= gnt_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
    end
  end

  assign gnt = gnt_q;
  assign AN  = an_q;
  assign CA  = ca_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Randomized scoreboard bench for sseg_arbiter against a frame-level reference model.
module tb_sseg_arbiter;

  localparam int N      = 1;
  localparam int Q      = 3;
  localparam int P      = 1 << N;
  localparam int CYCLES = 4000;

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] an;
    logic [6:0] ca;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [55:0] seg0;
  logic [55:0] seg1;
  logic [6:0]  CA;
  logic [7:0]  AN;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  bit   started;
  bit   done;

  // Reference model state: cycles since reset, owner (-1 = none), tie-break, frames held.
  int   m_phase;
  int   m_owner;
  int   m_rr;
  int   m_held;

  sseg_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .seg0 (seg0),
    .seg1 (seg1),
    .CA   (CA),
    .AN   (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict what the coming clock edge produces from the inputs now applied.
  task automatic model_step();
    exp_t e;
    int   digit;
    int   nxt;
    int   oth;
    bit   fe;
    logic [55:0] s;
    if (rst) begin
      m_phase = 0;
      m_owner = -1;
      m_rr    = 0;
      m_held  = 0;
      e.gnt   = 2'b00;
      e.an    = 8'hFF;
      e.ca    = 7'h7F;
    end else begin
      digit = (m_phase / P) % 8;
      if (m_owner < 0) begin
        e.an = 8'hFF;
        e.ca = 7'h7F;
      end else begin
        s    = (m_owner == 0) ? seg0 : seg1;
        e.an = 8'hFF ^ (8'h01 << digit);
        e.ca = s[digit * 7 +: 7];
      end
      fe  = ((m_phase % P) == P - 1) && (digit == 7);
      nxt = m_owner;
      if (fe) begin
        if (m_owner < 0) begin
          if (req == 2'b01) nxt = 0;
          else if (req == 2'b10) nxt = 1;
          else if (req == 2'b11) nxt = m_rr;
          else nxt = -1;
        end else begin
          oth = 1 - m_owner;
          if (!req[m_owner]) nxt = req[oth] ? oth : -1;
          else if (req[oth] && m_held == Q - 1) nxt = oth;
          else nxt = m_owner;
        end
        if (nxt != m_owner) begin
          m_held = 0;
          if (nxt >= 0) m_rr = 1 - nxt;
        end else if (m_owner >= 0 && m_held < Q - 1) begin
          m_held = m_held + 1;
        end
      end
      m_owner = nxt;
      m_phase = (m_phase + 1) % (8 * P);
      e.gnt   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    end
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  // Stimulus: random request runs, occasional pattern changes and resets.
  initial begin
    int run_left;
    int rst_left;
    tests    = 0;
    fails    = 0;
    started  = 1'b0;
    done     = 1'b0;
    run_left = 0;
    rst_left = 2;
    rst  = 1'b1;
    req  = 2'b00;
    seg0 = {$urandom(), $urandom()};
    seg1 = {$urandom(), $urandom()};
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      if (rst_left > 0) begin
        rst      = 1'b1;
        rst_left = rst_left - 1;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      end
      if (run_left == 0) begin
        req      = 2'($urandom_range(0, 3));
        run_left = $urandom_range(1, 120);
      end else begin
        run_left = run_left - 1;
      end
      if ($urandom_range(0, 7) == 0) seg0 = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) seg1 = {$urandom(), $urandom()};
      model_step();
      @(negedge clk);
    end
    done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: after every edge the DUT presents outputs; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests = tests + 3;
        if (gnt !== e.gnt) begin
          fails = fails + 1;
          $display("FAIL gnt at %0t: got %b, required %b", $time, gnt, e.gnt);
        end
        if (AN !== e.an) begin
          fails = fails + 1;
          $display("FAIL AN at %0t: got %h, required %h", $time, AN, e.an);
        end
        if (CA !== e.ca) begin
          fails = fails + 1;
          $display("FAIL CA at %0t: got %h, required %h", $time, CA, e.ca);
        end
      end else if (started && !done) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL underflow at %0t: no expected response queued, required one", $time);
      end
    end
  end

endmodule

// File: doc/sseg_arbiter.md
# sseg_arbiter

- Shares the 8-digit seven-segment display (active-low CA[6:0] and AN[7:0]) between two pattern sources, such as `rotating_square` and a text ticker.
- Owns the digit scan, grants the display to one requester at a time and switches owners only at frame boundaries, so a frame never tears.
- Sits between the pattern generators and the board pins; the generators only supply static per-digit segment patterns.

## Interface
Parameters:
- N, 18: prescaler width; one scan tick every 2^N clk cycles (N=1 in simulation).
- QUANTUM, 4: frames a requester keeps the display while the other is also requesting; legal range 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  req[k] = source k wants the display.
- gnt  out  2  one-hot or zero; gnt[k] = source k owns the display.
- seg0  in  56  source 0 patterns; digit d = seg0[7d+6:7d], active-low, segment order g..a.
- seg1  in  56  source 1 patterns, same layout as seg0.
- CA  out  7  active-low cathodes of the currently scanned digit.
- AN  out  8  active-low anodes; at most one bit low.

## Operation
- Prescaler: N-bit free-running counter. `tick` is asserted on the cycle the counter equals 2^N-1.
- Scan index idx (3 bits): increments on tick and wraps 7→0.
- `frame_end` = tick && idx==7.
- FSM states: IDLE, OWN0, OWN1. All transitions are evaluated only on frame_end.
- Transitions from IDLE:
  - req==2'b01 → OWN0.
  - req==2'b10 → OWN1.
  - req==2'b11 → owner given by the round-robin pointer rr.
  - req==2'b00 → stay in IDLE.
- Transitions from OWNk:
  - req[k]==0 → OWN(other) if req[other], else IDLE.
  - req[k]==1 && req[other]==1 && fcnt==QUANTUM-1 → OWN(other).
  - otherwise stay in OWNk.
- rr: set to the index not most recently granted on every entry into an OWN state. Reset value 0, so source 0 wins the first contention.
- fcnt (8 bits): cleared on every state change and on reset. Increments on frame_end while in an OWN state; saturates at QUANTUM-1.
- gnt is decoded from the state: gnt[0] in OWN0, gnt[1] in OWN1, 2'b00 in IDLE.
- Early release: a requester dropping req mid-frame keeps gnt until frame_end. Its seg inputs must stay valid while gnt[k]=1.
- Outputs:
  - In OWNk: AN = ~(8'b1<<idx), CA = segk digit idx.
  - In IDLE: AN=8'hFF and CA=7'h7F (blank).

## Timing
- Reset values: prescaler=0, idx=0, state=IDLE, rr=0, fcnt=0, gnt=2'b00, AN=8'hFF, CA=7'h7F.
- Reset mid-frame blanks the display on the next edge and restarts the scan at digit 0.
- State, idx and gnt update on the same edge (the edge where tick/frame_end is sampled).
- AN and CA are registered from the post-edge state and idx, so they lag gnt/idx by exactly 1 clk.
- Grant latency, from req rising while IDLE to gnt rising: at most 8·2^N clk (next frame_end). Worst case under contention: QUANTUM frames.
- Simultaneous drop of req[k] and rise of req[other] at frame_end: the owner switches on that edge.
- Changes to seg inputs are visible on CA 1 clk after the edge where idx selects that digit.

## Structure
- Package `sseg_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`.
  - Constants `AN_OFF=8'hFF` and `CA_OFF=7'h7F`.
- Sub-module `sseg_scan_timer #(N)`:
  - Contains the prescaler and idx.
  - Outputs idx, tick, frame_end.
  - Reused by other display blocks.
- Top level: FSM, rr, fcnt, gnt decode and the registered output mux.

## Test plan
All scenarios use N=1, so tick is every 2 clk and a frame is 16 clk.
- Reset: rst high for 2 clk → AN=FF, CA=7F, gnt=00. After release, idx walks 0..7 every 2 clk with AN still FF.
- Single requester: req=01 at clk 3 → gnt=01 at the first frame_end (clk 16). Next cycle AN=FE with CA=seg0[6:0]; AN then steps FD, FB, …, 7F every 2 clk.
- Contention, QUANTUM=4, req=11 from reset → gnt sequence 01 (4 frames), 10 (4 frames), 01, … Each switch happens exactly at frame_end.
- Early release: owner 0 drops req at mid-frame digit 3 while req[1]=0 → gnt stays 01 until frame_end, then 00 and AN=FF one clk later.
- Handover: req[0] falls and req[1] rises on the same frame_end cycle → gnt goes 01→10 on that edge. AN shows seg1 digit 0 one clk later; no blank frame.
- Reset mid-frame at idx=5 while gnt=10 → next edge gnt=00, idx=0, AN=FF, fcnt=0.
